// File: rtl/jpeg_sched_pkg.sv
// Shared definitions for the JPEG block scheduler: FSM state encoding and
// output channel codes.
// Build option: JPEG_SCHED_LUMA_ONLY_EN -- when defined, the last channel sent
// per block is Y (luma-only pipeline); otherwise Y, Cb, Cr are sent in order.
package jpeg_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_START   = 4'd2,
    S_WAIT    = 4'd3,
    S_CAPTURE = 4'd4,
    S_SEND    = 4'd5,
    S_NEXT    = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } sched_state_t;

  localparam logic [1:0] CH_Y  = 2'd0;
  localparam logic [1:0] CH_CB = 2'd1;
  localparam logic [1:0] CH_CR = 2'd2;

`ifdef JPEG_SCHED_LUMA_ONLY_EN
  localparam logic [1:0] CH_LAST = CH_Y;
`else
  localparam logic [1:0] CH_LAST = CH_CR;
`endif

endpackage

// File: rtl/jpeg_sched_timeout.sv
// Handshake watchdog shared by the load and send phases.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear (no request outstanding)
//   en          count one waiting cycle
//   expired_c   combinational: current cycle is the last one allowed
//               (the TIMEOUT_CYCLES-th cycle of an outstanding request)
module jpeg_sched_timeout
  import jpeg_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // An ack arriving on this cycle still wins over the expiry.
  assign expired_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturating wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jpeg_block_scheduler.sv
// Frame-level sequencer for the 8x8 JPEG datapath. Walks blocks in raster
// order: load RGB block, pulse the pipeline, wait its latency, capture, then
// request the Y/Cb/Cr output bursts.
// Build option: JPEG_SCHED_LUMA_ONLY_EN (Y burst only per block).
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   cfg_start, cfg_blocks_x/y     frame start and dimensions (in blocks)
//   cfg_busy, cfg_done, cfg_error frame status (error is sticky)
//   load_req, load_bx/by, load_done   RGB block loader handshake
//   pipe_start, pipe_capture      pipeline strobes
//   send_req, send_chan, send_last, send_done   output burst handshake
// All outputs are registered.
module jpeg_block_scheduler
  import jpeg_sched_pkg::*;
#(
  parameter int unsigned BLK_BITS       = 8,
  parameter int unsigned PIPE_LATENCY   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cfg_start,
  input  logic [BLK_BITS-1:0] cfg_blocks_x,
  input  logic [BLK_BITS-1:0] cfg_blocks_y,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic                load_req,
  output logic [BLK_BITS-1:0] load_bx,
  output logic [BLK_BITS-1:0] load_by,
  input  logic                load_done,
  output logic                pipe_start,
  output logic                pipe_capture,
  output logic                send_req,
  output logic [1:0]          send_chan,
  output logic                send_last,
  input  logic                send_done
);

  localparam int unsigned LAT_W = (PIPE_LATENCY > 2) ? $clog2(PIPE_LATENCY) : 1;

  sched_state_t        state_q, state_d;
  logic [BLK_BITS-1:0] dim_x, dim_y, dim_x_d, dim_y_d;
  logic [BLK_BITS-1:0] bx_d, by_d;
  logic [1:0]          chan_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                error_d, busy_d, done_d, load_req_d;
  logic                pipe_start_d, pipe_capture_d, send_req_d, send_last_d;
  logic                last_blk;
  logic                req_active;
  logic                to_expired;

  assign last_blk   = (load_bx == dim_x - BLK_BITS'(1)) && (load_by == dim_y - BLK_BITS'(1));
  assign req_active = load_req | send_req;

  // Watchdog restarts whenever no request is outstanding (state entry, burst gap).
  jpeg_sched_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (aclk),
    .rst_n    (aresetn),
    .clr      (!req_active),
    .en       (req_active),
    .expired_c(to_expired)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    dim_x_d    = dim_x;
    dim_y_d    = dim_y;
    bx_d       = load_bx;
    by_d       = load_by;
    chan_d     = send_chan;
    lat_d      = lat_q;
    error_d    = cfg_error;
    send_req_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          dim_x_d = cfg_blocks_x;
          dim_y_d = cfg_blocks_y;
          error_d = 1'b0;
          if (cfg_blocks_x == '0 || cfg_blocks_y == '0) begin
            error_d = 1'b1;
          end else begin
            bx_d    = '0;
            by_d    = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (load_req && load_done) begin
          state_d = S_START;
        end else if (to_expired) begin
          state_d = S_ERR;
        end
      end
      S_START: begin
        lat_d   = '0;
        state_d = (PIPE_LATENCY > 1) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        // PIPE_LATENCY-1 wait cycles put capture PIPE_LATENCY after start.
        if (lat_q == LAT_W'(PIPE_LATENCY - 2)) begin
          state_d = S_CAPTURE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_CAPTURE: begin
        chan_d     = CH_Y;
        send_req_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (!send_req) begin
          // one-cycle gap between bursts; re-raise the request
          send_req_d = 1'b1;
        end else if (send_done) begin
          if (send_chan == CH_LAST) begin
            state_d = S_NEXT;
          end else begin
            chan_d = send_chan + 2'd1;
          end
        end else if (to_expired) begin
          state_d = S_ERR;
        end else begin
          send_req_d = 1'b1;
        end
      end
      S_NEXT: begin
        // Coordinates stay on the final block once the frame completes.
        if (last_blk) begin
          state_d = S_DONE;
        end else begin
          if (load_bx == dim_x - BLK_BITS'(1)) begin
            bx_d = '0;
            by_d = load_by + BLK_BITS'(1);
          end else begin
            bx_d = load_bx + BLK_BITS'(1);
          end
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERR) begin
      error_d = 1'b1;
    end

    busy_d         = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERR);
    done_d         = (state_d == S_DONE);
    load_req_d     = (state_d == S_LOAD);
    pipe_start_d   = (state_d == S_START);
    pipe_capture_d = (state_d == S_CAPTURE);
    send_last_d    = send_req_d && (chan_d == CH_LAST) && last_blk;
  end

  // State and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      dim_x        <= '0;
      dim_y        <= '0;
      lat_q        <= '0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_error    <= 1'b0;
      load_req     <= 1'b0;
      load_bx      <= '0;
      load_by      <= '0;
      pipe_start   <= 1'b0;
      pipe_capture <= 1'b0;
      send_req     <= 1'b0;
      send_chan    <= 2'd0;
      send_last    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dim_x        <= dim_x_d;
      dim_y        <= dim_y_d;
      lat_q        <= lat_d;
      cfg_busy     <= busy_d;
      cfg_done     <= done_d;
      cfg_error    <= error_d;
      load_req     <= load_req_d;
      load_bx      <= bx_d;
      load_by      <= by_d;
      pipe_start   <= pipe_start_d;
      pipe_capture <= pipe_capture_d;
      send_req     <= send_req_d;
      send_chan    <= chan_d;
      send_last    <= send_last_d;
    end
  end

endmodule

// File: tb/tb_jpeg_block_scheduler.sv
// Self-checking bench for jpeg_block_scheduler: table of frames plus random
// frames, scored against a list-based model of the expected handshakes.
module tb_jpeg_block_scheduler;

  localparam int PL    = 2;
  localparam int TO    = 16;
  localparam int NEVER = 1000;
  localparam int LIMIT = 3000;
`ifdef JPEG_SCHED_LUMA_ONLY_EN
  localparam int NCH = 1;
`else
  localparam int NCH = 3;
`endif

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       cfg_start = 1'b0;
  logic [7:0] cfg_blocks_x = 8'd0;
  logic [7:0] cfg_blocks_y = 8'd0;
  logic       cfg_busy, cfg_done, cfg_error;
  logic       load_req;
  logic [7:0] load_bx, load_by;
  logic       load_done = 1'b0;
  logic       pipe_start, pipe_capture;
  logic       send_req;
  logic [1:0] send_chan;
  logic       send_last;
  logic       send_done = 1'b0;

  jpeg_block_scheduler #(
    .BLK_BITS(8), .PIPE_LATENCY(PL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start),
    .cfg_blocks_x(cfg_blocks_x), .cfg_blocks_y(cfg_blocks_y),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .load_req(load_req), .load_bx(load_bx), .load_by(load_by), .load_done(load_done),
    .pipe_start(pipe_start), .pipe_capture(pipe_capture),
    .send_req(send_req), .send_chan(send_chan), .send_last(send_last), .send_done(send_done)
  );

  initial forever #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  // responder / monitor state (written only by the monitor process)
  int   cyc = 0, done_cnt = 0, pipe_cnt = 0, busy_cyc = 0, viol_cnt = 0, start_cyc = 0;
  int   lcnt = 0, scnt = 0, ldelay = 0, sdelay = 0;
  logic prev_lr = 0, prev_sr = 0, prev_ps = 0, prev_busy = 0;
  logic [7:0] rise_bx, rise_by;
  logic [1:0] rise_ch;
  logic       rise_last;
  int   ml_x[$], ml_y[$], ms_ch[$], ms_last[$];

  // responder configuration (written only by the main process); <0 = random per request
  int ld_mode = 0, sd_mode = 0;
  bit noise = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({cfg_busy, cfg_done, cfg_error, load_req, load_bx, load_by,
                 pipe_start, pipe_capture, send_req, send_chan, send_last});
  endfunction

  // Loader/sender responders plus protocol monitor, all sampled on the falling edge.
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        load_done = 1'b0; send_done = 1'b0;
        prev_lr = 1'b0; prev_sr = 1'b0; prev_ps = 1'b0; prev_busy = 1'b0;
      end else begin
        load_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (load_req) begin
          if (!prev_lr) begin
            ldelay = (ld_mode < 0) ? int'($urandom_range(0, TO - 1)) : ld_mode;
            lcnt = 0;
            ml_x.push_back(int'(load_bx));
            ml_y.push_back(int'(load_by));
            rise_bx = load_bx; rise_by = load_by;
          end else if (load_bx != rise_bx || load_by != rise_by) begin
            viol_cnt++;
          end
          load_done = (lcnt >= ldelay);
          lcnt++;
        end
        send_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (send_req) begin
          if (!prev_sr) begin
            sdelay = (sd_mode < 0) ? int'($urandom_range(0, TO - 1)) : sd_mode;
            scnt = 0;
            ms_ch.push_back(int'(send_chan));
            ms_last.push_back(int'(send_last));
            rise_ch = send_chan; rise_last = send_last;
          end else if (send_chan != rise_ch || send_last != rise_last) begin
            viol_cnt++;
          end
          send_done = (scnt >= sdelay);
          scnt++;
        end else if (send_last) begin
          viol_cnt++;
        end
        if (pipe_start) begin
          pipe_cnt++;
          if (prev_ps) viol_cnt++;
          start_cyc = cyc;
        end
        if (pipe_capture && (cyc - start_cyc != PL)) viol_cnt++;
        if (cfg_busy) busy_cyc++;
        if (cfg_done) begin
          done_cnt++;
          if (cfg_busy || !prev_busy) viol_cnt++;
        end
        prev_lr = load_req; prev_sr = send_req; prev_ps = pipe_start; prev_busy = cfg_busy;
      end
    end
  end

  // Runs one frame (called on a falling edge) and scores it against the model.
  task automatic run_frame(input string tag, input int x, input int y, input int ld,
                           input int sd, input bit mid, input int exp_err, input int exp_done);
    int ex[$], ey[$], ec[$], el[$];
    int lb, sb, db, pb, bb, vb, n, nblk, exp_pipes;
    bit zero;
    zero = (x == 0 || y == 0);
    nblk = zero ? 0 : x * y;
    for (int b = 0; b < nblk; b++) begin
      ex.push_back(b % x);
      ey.push_back(b / x);
      if (ld >= TO) break;
      for (int c = 0; c < NCH; c++) begin
        ec.push_back(c);
        el.push_back((b == nblk - 1 && c == NCH - 1) ? 1 : 0);
        if (sd >= TO) break;
      end
      if (sd >= TO) break;
    end
    exp_pipes = (zero || ld >= TO) ? 0 : ((sd >= TO) ? 1 : nblk);

    lb = ml_x.size(); sb = ms_ch.size(); db = done_cnt; pb = pipe_cnt;
    bb = busy_cyc; vb = viol_cnt;
    ld_mode = ld; sd_mode = sd; noise = (ld < 0);
    cfg_blocks_x = 8'(x); cfg_blocks_y = 8'(y); cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    check({tag, "/err_after_start"}, int'(cfg_error), int'(zero));
    check({tag, "/busy_after_start"}, int'(cfg_busy), int'(!zero));
    n = 0;
    while (done_cnt == db && !cfg_error && n < LIMIT) begin
      @(negedge aclk);
      n++;
      cfg_start = (mid && n == 10);
      if (mid && n == 10) begin
        cfg_blocks_x = 8'd7; cfg_blocks_y = 8'd0;
      end
    end
    cfg_start = 1'b0;
    check({tag, "/finished_in_time"}, int'(n < LIMIT), 1);
    repeat (3) @(negedge aclk);
    noise = 1'b0;

    check({tag, "/cfg_error"}, int'(cfg_error), exp_err);
    check({tag, "/done_pulses"}, done_cnt - db, exp_done);
    check({tag, "/busy_idle"}, int'(cfg_busy), 0);
    check({tag, "/busy_seen"}, int'(busy_cyc > bb), int'(!zero));
    check({tag, "/pipe_starts"}, pipe_cnt - pb, exp_pipes);
    check({tag, "/protocol_viol"}, viol_cnt - vb, 0);
    check({tag, "/load_count"}, ml_x.size() - lb, ex.size());
    for (int i = 0; i < ex.size() && lb + i < ml_x.size(); i++) begin
      check($sformatf("%s/load%0d_bx", tag, i), ml_x[lb + i], ex[i]);
      check($sformatf("%s/load%0d_by", tag, i), ml_y[lb + i], ey[i]);
    end
    check({tag, "/send_count"}, ms_ch.size() - sb, ec.size());
    for (int i = 0; i < ec.size() && sb + i < ms_ch.size(); i++) begin
      check($sformatf("%s/send%0d_chan", tag, i), ms_ch[sb + i], ec[i]);
      check($sformatf("%s/send%0d_last", tag, i), ms_last[sb + i], el[i]);
    end
    if (!zero) begin
      check({tag, "/final_bx"}, int'(load_bx), (exp_done != 0) ? x - 1 : 0);
      check({tag, "/final_by"}, int'(load_by), (exp_done != 0) ? y - 1 : 0);
    end
  endtask

  typedef struct {
    int x; int y; int ld; int sd; bit mid; int exp_err; int exp_done;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   n, db;
    int   rx, ry;

    vecs.push_back('{2, 1, 0,        0,        1'b0, 0, 1});
    vecs.push_back('{1, 1, 0,        0,        1'b0, 0, 1});
    vecs.push_back('{3, 0, 0,        0,        1'b0, 1, 0});
    vecs.push_back('{2, 2, 1,        2,        1'b0, 0, 1});
    vecs.push_back('{1, 1, NEVER,    0,        1'b0, 1, 0});
    vecs.push_back('{1, 1, TO - 1,   0,        1'b0, 0, 1});
    vecs.push_back('{2, 2, 0,        0,        1'b1, 0, 1});
    vecs.push_back('{2, 1, 0,        NEVER,    1'b0, 1, 0});
    vecs.push_back('{1, 2, 0,        TO - 1,   1'b0, 0, 1});
    vecs.push_back('{0, 0, 0,        0,        1'b0, 1, 0});
    vecs.push_back('{3, 2, -1,       -1,       1'b0, 0, 1});

    repeat (2) @(negedge aclk);
    check("reset/outputs_held", all_outs(), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("reset/outputs_after_release", all_outs(), 0);

    foreach (vecs[i]) begin
      run_frame($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].ld, vecs[i].sd,
                vecs[i].mid, vecs[i].exp_err, vecs[i].exp_done);
    end

    // asynchronous reset while a send burst is outstanding
    ld_mode = 0; sd_mode = 5;
    db = done_cnt;
    cfg_blocks_x = 8'd2; cfg_blocks_y = 8'd2; cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    n = 0;
    while (!send_req && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("rst_mid/reached_send", int'(send_req), 1);
    #2 aresetn = 1'b0;
    #1 check("rst_mid/outputs_immediate", all_outs(), 0);
    @(negedge aclk);
    check("rst_mid/outputs_next_edge", all_outs(), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_mid/no_done", done_cnt - db, 0);
    check("rst_mid/no_error", int'(cfg_error), 0);
    check("rst_mid/idle_outputs", all_outs(), 0);
    run_frame("after_rst", 2, 1, 0, 0, 1'b0, 0, 1);

    // random dimensions, random ack latencies and stray acks
    for (int i = 0; i < 8; i++) begin
      rx = int'($urandom_range(0, 4));
      ry = int'($urandom_range(0, 3));
      run_frame($sformatf("rnd%0d_%0dx%0d", i, rx, ry), rx, ry, -1, -1, 1'b0,
                (rx == 0 || ry == 0) ? 1 : 0, (rx == 0 || ry == 0) ? 0 : 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
